ex_mem_wb_pipe: RTL
===================

EX_MEM_WB_PIPE -- requirements
Module: ex_mem_wb_pipe

Interface
REQ-001 SHALL have parameter CNT_W, default 32: retire-counter width.
REQ-002 SHALL have ports clk_i  in  1  clock, single clock domain; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports ex_valid_i, ex_flush_i, ex_RegWrite_i, ex_MemtoReg_i, ex_MemRead_i, ex_MemWrite_i, each in 1: EX-stage instruction attributes and flush request.
REQ-005 SHALL have ports ex_RDaddr_i  in  5 (destination register), ex_ALUres_i  in  32 (ALU result) and ex_RS2data_i  in  32 (store data).
REQ-006 SHALL have ports mem_ready_i  in  1 (data memory done this cycle) and mem_rdata_i  in  32 (load data).
REQ-007 SHALL have ports mem_addr_o  out  32, mem_wdata_o  out  32, mem_re_o  out  1 and mem_we_o  out  1 (data memory request).
REQ-008 SHALL have ports MEM_RegWrite_o  out  1, MEM_RDaddr_o  out  5 and MEM_ALUres_o  out  32 (forwarding source, MEM stage).
REQ-009 SHALL have ports WB_RegWrite_o  out  1, WB_RDaddr_o  out  5 and WB_data_o  out  32 (register-file write and forwarding source, WB stage).
REQ-010 SHALL have ports stall_o  out  1 (freeze IF/ID/EX) and retired_o  out  CNT_W (retired-instruction count).

Function
REQ-011 SHALL hold two register stages, MEM and WB, each with a valid bit plus payload.
REQ-012 SHALL assert stall_o combinationally when MEM is valid, (MemRead or MemWrite) is set, and mem_ready_i=0.
REQ-013 SHALL, when stall_o=0, load MEM on each edge from the EX inputs, with valid = ex_valid_i AND NOT ex_flush_i.
REQ-014 SHALL, when stall_o=1, hold MEM unchanged and ignore ex_flush_i; keeping EX stable is the upstream stage's duty.
REQ-015 SHALL, when stall_o=0, move MEM to WB on each edge: WB data = mem_rdata_i when MemtoReg is set, else ALUres.
REQ-016 SHALL load a bubble (valid=0) into WB on each edge where stall_o=1.
REQ-017 SHALL drive mem_re_o = MEM valid AND MemRead and mem_we_o = MEM valid AND MemWrite, with mem_addr_o = MEM ALUres and mem_wdata_o = MEM RS2data, all held stable while stall_o=1.
REQ-018 SHALL drive MEM_RegWrite_o = MEM valid AND RegWrite AND (RDaddr != 0); the WB_RegWrite_o rule is the same for the WB stage.
REQ-019 SHALL drive MEM_RDaddr_o, MEM_ALUres_o, WB_RDaddr_o and WB_data_o directly from stage payload, regardless of the valid bits.
REQ-020 SHALL give an EX-to-WB latency of 2 edges with no stall, plus one edge per cycle of mem_ready_i=0.
REQ-021 SHALL assert MEM_RegWrite_o for loads as well as other writes; load-use stalls belong to the hazard unit, not this block.
REQ-022 SHALL increment retired_o on each edge where WB is valid, and saturate at all-ones with no wrap.
REQ-023 SHALL treat an instruction with both MemRead and MemWrite set as a load for stall purposes, driving both strobes.

Reset
REQ-024 SHALL, while rst_i=0, asynchronously clear both valid bits, all payloads and retired_o to 0, so every output reads 0 including stall_o.
REQ-025 SHALL discard an in-flight memory access when reset asserts during a stall; after release the first capture occurs on the first edge.

Structure
REQ-026 SHALL take the register-address width (5), data width (32) and x0 constant from the shared CPU package, along with a MEM-stage payload struct and a WB-stage payload struct.
REQ-027 SHALL be a single module with no sub-modules; the saturating counter stays inline.

Verification
REQ-028 Bench SHALL check ALU op x5=0x1234 with RegWrite=1: MEM_RegWrite_o=1 and RDaddr=5 in cycle 1, WB_data_o=0x1234 in cycle 2, and retired_o increments by 1.
REQ-029 Bench SHALL check a load to x7 with mem_ready_i=0 for 3 cycles then rdata=0xDEADBEEF: stall_o=1 for exactly 3 cycles, address stable, WB bubbles, then WB_data_o=0xDEADBEEF.
REQ-030 Bench SHALL check ex_flush_i=1 with ex_valid_i=1: MEM_RegWrite_o=0 and mem_we_o=0 next cycle, and retired_o is unchanged.
REQ-031 Bench SHALL check a write to x0 with RegWrite=1: MEM_RegWrite_o and WB_RegWrite_o both stay 0, and retired_o still increments.
REQ-032 Bench SHALL check rst_i driven low mid-stall: all outputs 0 immediately without a clock edge, and after release the next instruction flows normally.
REQ-033 Bench SHALL check CNT_W=4 with 20 back-to-back valid instructions: retired_o saturates at 15.

Source files
------------

// File: rtl/ex_mem_wb_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package : ex_mem_wb_pipe_pkg
// Brief   : Shared CPU widths, x0 constant and MEM/WB stage payload types.
// Revision: 1.0 - initial release
// ============================================================================
package ex_mem_wb_pipe_pkg;

  localparam int c_reg_aw = 5;
  localparam int c_xlen   = 32;
  localparam logic [c_reg_aw-1:0] c_x0 = '0;

  typedef struct packed {
    logic                reg_write;
    logic                mem_to_reg;
    logic                mem_read;
    logic                mem_write;
    logic [c_reg_aw-1:0] rd_addr;
    logic [c_xlen-1:0]   alu_res;
    logic [c_xlen-1:0]   rs2_data;
  } mem_payload_t;

  typedef struct packed {
    logic                reg_write;
    logic [c_reg_aw-1:0] rd_addr;
    logic [c_xlen-1:0]   data;
  } wb_payload_t;

  // A stage really writes the register file only if valid and not targeting x0.
  function automatic logic writes_reg(input logic valid, input logic reg_write,
                                      input logic [c_reg_aw-1:0] rd);
    return valid & reg_write & (rd != c_x0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_wb_pipe
// Brief   : MEM and WB pipeline registers with data-memory stall and a
//           saturating retired-instruction counter.
// Revision: 1.0 - initial release
// ============================================================================
module ex_mem_wb_pipe
  import ex_mem_wb_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ex_valid_i,
  input  logic                ex_flush_i,
  input  logic                ex_RegWrite_i,
  input  logic                ex_MemtoReg_i,
  input  logic                ex_MemRead_i,
  input  logic                ex_MemWrite_i,
  input  logic [c_reg_aw-1:0] ex_RDaddr_i,
  input  logic [c_xlen-1:0]   ex_ALUres_i,
  input  logic [c_xlen-1:0]   ex_RS2data_i,
  input  logic                mem_ready_i,
  input  logic [c_xlen-1:0]   mem_rdata_i,
  output logic [c_xlen-1:0]   mem_addr_o,
  output logic [c_xlen-1:0]   mem_wdata_o,
  output logic                mem_re_o,
  output logic                mem_we_o,
  output logic                MEM_RegWrite_o,
  output logic [c_reg_aw-1:0] MEM_RDaddr_o,
  output logic [c_xlen-1:0]   MEM_ALUres_o,
  output logic                WB_RegWrite_o,
  output logic [c_reg_aw-1:0] WB_RDaddr_o,
  output logic [c_xlen-1:0]   WB_data_o,
  output logic                stall_o,
  output logic [CNT_W-1:0]    retired_o
);

  logic         r_mem_valid;
  mem_payload_t r_mem;
  logic         r_wb_valid;
  wb_payload_t  r_wb;
  logic [CNT_W-1:0] r_retired;

  logic         w_stall;
  mem_payload_t w_ex_payload;

  // Loads and stores both wait on memory; a load+store pair counts as a load.
  assign w_stall = r_mem_valid & (r_mem.mem_read | r_mem.mem_write) & ~mem_ready_i;

  always_comb begin
    w_ex_payload            = '0;
    w_ex_payload.reg_write  = ex_RegWrite_i;
    w_ex_payload.mem_to_reg = ex_MemtoReg_i;
    w_ex_payload.mem_read   = ex_MemRead_i;
    w_ex_payload.mem_write  = ex_MemWrite_i;
    w_ex_payload.rd_addr    = ex_RDaddr_i;
    w_ex_payload.alu_res    = ex_ALUres_i;
    w_ex_payload.rs2_data   = ex_RS2data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem_valid <= 1'b0;
      r_mem       <= '0;
    end else if (!w_stall) begin
      r_mem_valid <= ex_valid_i & ~ex_flush_i;
      r_mem       <= w_ex_payload;
    end
  end

  // A stalled MEM stage emits a bubble into WB; WB payload is simply held.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wb_valid <= 1'b0;
      r_wb       <= '0;
    end else if (w_stall) begin
      r_wb_valid <= 1'b0;
    end else begin
      r_wb_valid     <= r_mem_valid;
      r_wb.reg_write <= r_mem.reg_write;
      r_wb.rd_addr   <= r_mem.rd_addr;
      r_wb.data      <= r_mem.mem_to_reg ? mem_rdata_i : r_mem.alu_res;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_retired <= '0;
    end else if (r_wb_valid && (r_retired != {CNT_W{1'b1}})) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  assign stall_o        = w_stall;
  assign mem_addr_o     = r_mem.alu_res;
  assign mem_wdata_o    = r_mem.rs2_data;
  assign mem_re_o       = r_mem_valid & r_mem.mem_read;
  assign mem_we_o       = r_mem_valid & r_mem.mem_write;
  assign MEM_RegWrite_o = writes_reg(r_mem_valid, r_mem.reg_write, r_mem.rd_addr);
  assign MEM_RDaddr_o   = r_mem.rd_addr;
  assign MEM_ALUres_o   = r_mem.alu_res;
  assign WB_RegWrite_o  = writes_reg(r_wb_valid, r_wb.reg_write, r_wb.rd_addr);
  assign WB_RDaddr_o    = r_wb.rd_addr;
  assign WB_data_o      = r_wb.data;
  assign retired_o      = r_retired;

endmodule
`default_nettype wire
